fifo_rd_prefetch: RTL and testbench
===================================

FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 R_CLK  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 R_RST  input  1  reset, asynchronous, active-low.
REQ-004 REMPTY  input  1  FIFO empty flag from the read-pointer stage, combinational in R_CLK domain.
REQ-005 RDATA  input  WIDTH  FIFO memory word at the current Raddr; asynchronous read, valid in the same cycle REMPTY=0.
REQ-006 FLUSH  input  1  synchronous discard of buffered words.
REQ-007 FETCH_EN  input  1  permits popping the FIFO when high.
REQ-008 R_INC  output  1  pop strobe to the read-pointer stage.
REQ-009 OUT_VALID  output  1  OUT_DATA holds a word.
REQ-010 OUT_READY  input  1  consumer accepts the word this cycle.
REQ-011 OUT_DATA  output  WIDTH  head word, driven directly from a register.
REQ-012 OCC  output  2  buffered word count, 0..2.

Function
REQ-013 Two-entry buffer, HEAD and SKID, with occupancy states S0, S1 and S2.
REQ-014 R_INC = R_RST & FETCH_EN & !REMPTY & !FLUSH & (state != S2), with no combinational path from OUT_READY.
REQ-015 Push (R_INC=1): RDATA is captured at the same R_CLK edge that advances the FIFO pointer, so the effective latency from FIFO to OUT_VALID is 1 cycle.
REQ-016 Pop: OUT_VALID & OUT_READY at the rising edge.
REQ-017 Transitions:
- S0 + push -> S1, RDATA into HEAD.
- S1 + push, no pop -> S2, RDATA into SKID.
- S1 + pop, no push -> S0.
- S1 + push + pop -> S1, RDATA into HEAD.
- S2 + pop -> S1, SKID into HEAD.
- S2 with no pop -> holds.
REQ-018 S2 never pushes, so no word is lost.
REQ-019 OUT_VALID = (state != S0).
REQ-020 OUT_DATA = HEAD.
REQ-021 OCC = 0, 1 or 2 to match S0, S1 or S2.
REQ-022 OUT_DATA and OUT_VALID are stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 FLUSH has priority over push and pop: next state is S0, R_INC=0 that cycle, and FIFO contents are untouched.
REQ-024 FETCH_EN=0 stops pushes only; buffered words continue to drain.
REQ-025 Sustained throughput is 1 word per cycle when FIFO is non-empty and OUT_READY=1.
REQ-026 Words leave in FIFO order, with none duplicated or dropped, including across FIFO pointer wrap-around.
REQ-027 REMPTY rising in the same cycle as a pop: no push, state follows REQ-017.

Reset
REQ-028 R_RST low: state S0, HEAD=0, SKID=0, OUT_VALID=0, OUT_DATA=0, OCC=0, R_INC=0 immediately (asynchronously).
REQ-029 Reset mid-transfer discards buffered words.
REQ-030 The first push is permitted on the first R_CLK edge after R_RST deasserts.

Structure
REQ-031 Shared package fifo_pkg holds WIDTH/DEPTH defaults and the occupancy-state enum (S0, S1, S2).
REQ-032 The block is a single module with no sub-module; the two storage registers and state register are local.

Verification
REQ-033 FIFO holding A5,3C,7E, OUT_READY=1 -> R_INC high 3 consecutive cycles; OUT_DATA A5,3C,7E on consecutive cycles; OCC returns to 0.
REQ-034 FIFO holding 11,22,33, OUT_READY=0 -> exactly 2 R_INC pulses; OCC=2; OUT_DATA=11 held. Then OUT_READY=1 -> 11,22,33 delivered in order.
REQ-035 State S2 with FLUSH=1 for one cycle -> OCC=0, OUT_VALID=0, R_INC=0 that cycle. The next FIFO word (44) appears on OUT_DATA after 1 cycle.
REQ-036 FETCH_EN=0 with FIFO non-empty -> R_INC stays 0. Buffered words still drain on OUT_READY=1.
REQ-037 R_RST pulsed low mid-stream with OCC=2 -> OUT_VALID=0, OCC=0, R_INC=0 during reset. After release, streaming resumes with no spurious word.
REQ-038 Random REMPTY/OUT_READY over 1000 words (DEPTH=16, multiple wraps) -> the output sequence equals the write sequence.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: default sizes and the
// occupancy-state encoding used by the read prefetch buffer.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // The encoding equals the number of buffered words, so OCC is the state itself.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } occ_state_e;

    function automatic logic [1:0] occ_of(input occ_state_e s);
        return logic'(s[1]) ? 2'd2 : (logic'(s[0]) ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/fifo_rd_prefetch_if.sv
// Signal bundle between the FIFO read-pointer stage, the prefetch buffer and
// its consumer. The master side is the prefetch buffer.
interface fifo_rd_prefetch_if #(
    parameter int WIDTH = fifo_pkg::DEFAULT_WIDTH
);
    import fifo_pkg::*;

    logic             REMPTY;
    logic [WIDTH-1:0] RDATA;
    logic             FLUSH;
    logic             FETCH_EN;
    logic             R_INC;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [1:0]       OCC;
    occ_state_e       dbg_state;

    // A word moves on OUT_* exactly at a rising edge where OUT_VALID and
    // OUT_READY are both high; OUT_VALID never depends on OUT_READY and once
    // raised it and OUT_DATA hold until that transfer happens (or FLUSH/reset).

    modport master (
        input  REMPTY, RDATA, FLUSH, FETCH_EN, OUT_READY,
        output R_INC, OUT_VALID, OUT_DATA, OCC, dbg_state
    );

    modport slave (
        output REMPTY, RDATA, FLUSH, FETCH_EN, OUT_READY,
        input  R_INC, OUT_VALID, OUT_DATA, OCC, dbg_state
    );

endinterface

// File: rtl/fifo_rd_prefetch.sv
// Two-entry read prefetch buffer (HEAD + SKID) that turns an asynchronous-read
// FIFO into a registered valid/ready stream at one word per cycle.
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               R_CLK,
    input  logic               R_RST,
    fifo_rd_prefetch_if.master bus
);

    occ_state_e       state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             push;
    logic             pop;

    // Fetch decision looks only at local state, never at OUT_READY, so the
    // consumer has no combinational path into the pointer stage.
    assign push = R_RST & bus.FETCH_EN & ~bus.REMPTY & ~bus.FLUSH & (state != S2);
    assign pop  = (state != S0) & bus.OUT_READY;

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state <= S0;
            head  <= '0;
            skid  <= '0;
        end else if (bus.FLUSH) begin
            state <= S0;
        end else begin
            case (state)
                S0: begin
                    if (push) begin
                        head  <= bus.RDATA;
                        state <= S1;
                    end
                end
                S1: begin
                    case ({push, pop})
                        2'b10: begin
                            skid  <= bus.RDATA;
                            state <= S2;
                        end
                        2'b01: state <= S0;
                        2'b11: head <= bus.RDATA;
                        default: state <= S1;
                    endcase
                end
                S2: begin
                    if (pop) begin
                        head  <= skid;
                        state <= S1;
                    end
                end
                default: state <= S0;
            endcase
        end
    end

    assign bus.R_INC     = push;
    assign bus.OUT_VALID = (state != S0);
    assign bus.OUT_DATA  = head;
    assign bus.OCC       = occ_of(state);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: a small 16-deep FIFO model feeds the DUT and a
// queue-based reference of the two-word buffer predicts every output.
module tb_fifo_rd_prefetch;
    import fifo_pkg::*;

    localparam int W = 8;

    logic R_CLK;
    logic R_RST;

    fifo_rd_prefetch_if #(.WIDTH(W)) bus ();

    fifo_rd_prefetch #(.WIDTH(W)) dut (
        .R_CLK (R_CLK),
        .R_RST (R_RST),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial R_CLK = 1'b0;
    always #5 R_CLK = ~R_CLK;

    // ---------------- FIFO environment ----------------
    logic [W-1:0] mem [DEFAULT_DEPTH];
    logic [4:0]   wptr;
    logic [4:0]   rptr;
    logic         hide;

    assign bus.REMPTY = (wptr == rptr) || hide;
    assign bus.RDATA  = mem[rptr[3:0]];

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mq[$];
    logic         cyc_inc[$];
    logic         cyc_pop[$];
    logic [W-1:0] cyc_dat[$];
    int           n_checks;
    int           n_fail;
    int           n_deliv;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
        end
    endtask

    function automatic logic fifo_full();
        return (wptr - rptr) == 5'd16;
    endfunction

    task automatic fifo_write(input logic [W-1:0] word);
        if (!fifo_full()) begin
            mem[wptr[3:0]] = word;
            wptr = wptr + 5'd1;
            exp_q.push_back(word);
        end
    endtask

    task automatic drop_buffered();
        for (int i = 0; i < mq.size(); i++) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        mq.delete();
    endtask

    // One clock: called at a falling edge with inputs already driven.
    task automatic cycle();
        logic         exp_inc;
        logic         act_inc;
        logic         pop;
        logic         push;
        logic [W-1:0] word;
        logic [W-1:0] dut_data;
        logic         was_flush;
        #1;
        exp_inc = R_RST && bus.FETCH_EN && !bus.REMPTY && !bus.FLUSH && (mq.size() < 2);
        act_inc = bus.R_INC;
        check("r_inc", act_inc, exp_inc);
        check("out_valid", bus.OUT_VALID, mq.size() != 0);
        check("occ", bus.OCC, mq.size());
        if (mq.size() != 0) check("out_data", bus.OUT_DATA, mq[0]);
        dut_data  = bus.OUT_DATA;
        was_flush = bus.FLUSH;
        pop       = (mq.size() != 0) && bus.OUT_READY && R_RST;
        push      = exp_inc;
        word      = mem[rptr[3:0]];
        cyc_inc.push_back(act_inc);
        cyc_pop.push_back(pop && !was_flush);
        cyc_dat.push_back(dut_data);
        @(posedge R_CLK);
        #1;
        if (was_flush) begin
            drop_buffered();
        end else begin
            if (pop) begin
                n_deliv++;
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("sb_order", dut_data, exp_q.pop_front());
                void'(mq.pop_front());
            end
            if (push) mq.push_back(word);
        end
        if (act_inc) rptr = rptr + 5'd1;
        @(negedge R_CLK);
    endtask

    task automatic clear_logs();
        cyc_inc.delete();
        cyc_pop.delete();
        cyc_dat.delete();
    endtask

    task automatic set_inputs(input logic fe, input logic rdy, input logic fl);
        bus.FETCH_EN  = fe;
        bus.OUT_READY = rdy;
        bus.FLUSH     = fl;
        hide          = 1'b0;
    endtask

    task automatic drain();
        int n;
        set_inputs(1'b1, 1'b1, 1'b0);
        n = 0;
        while ((mq.size() != 0 || wptr != rptr) && n < 100) begin
            cycle();
            n++;
        end
        check("drain_done", (mq.size() != 0 || wptr != rptr), 0);
        check("drain_sb_empty", exp_q.size(), 0);
    endtask

    function automatic int sum_q(input logic q[$], input int from, input int to);
        int s = 0;
        for (int i = from; i <= to && i < q.size(); i++) s += int'(q[i]);
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int writes;
        int start;
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        n_deliv  = 0;
        wptr     = '0;
        rptr     = '0;
        for (int i = 0; i < DEFAULT_DEPTH; i++) mem[i] = '0;
        R_RST = 1'b0;
        set_inputs(1'b1, 1'b0, 1'b0);

        // Reset state, with a word already waiting in the FIFO.
        fifo_write(8'h5A);
        repeat (2) @(negedge R_CLK);
        #1;
        check("rst_r_inc", bus.R_INC, 0);
        check("rst_out_valid", bus.OUT_VALID, 0);
        check("rst_occ", bus.OCC, 0);
        check("rst_out_data", bus.OUT_DATA, 0);
        @(negedge R_CLK);
        R_RST = 1'b1;
        // First edge after release must already fetch.
        cycle();
        drain();

        // Streaming three words with the consumer ready.
        clear_logs();
        fifo_write(8'hA5); fifo_write(8'h3C); fifo_write(8'h7E);
        set_inputs(1'b1, 1'b1, 1'b0);
        repeat (5) cycle();
        check("s3_inc_run", sum_q(cyc_inc, 0, 2), 3);
        check("s3_inc_stop", cyc_inc[3], 0);
        check("s3_pop_run", sum_q(cyc_pop, 1, 3), 3);
        check("s3_data0", cyc_dat[1], 8'hA5);
        check("s3_data1", cyc_dat[2], 8'h3C);
        check("s3_data2", cyc_dat[3], 8'h7E);
        check("s3_occ_end", bus.OCC, 0);

        // Back-pressure: only two fetches, head held.
        clear_logs();
        fifo_write(8'h11); fifo_write(8'h22); fifo_write(8'h33);
        set_inputs(1'b1, 1'b0, 1'b0);
        repeat (5) cycle();
        check("bp_inc_count", sum_q(cyc_inc, 0, 4), 2);
        check("bp_occ", bus.OCC, 2);
        check("bp_head", bus.OUT_DATA, 8'h11);
        drain();

        // Flush from S2 with one word still in the FIFO.
        fifo_write(8'h55); fifo_write(8'h66); fifo_write(8'h44);
        set_inputs(1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        check("fl_pre_occ", bus.OCC, 2);
        bus.FLUSH = 1'b1;
        cycle();
        bus.FLUSH = 1'b0;
        check("fl_occ", bus.OCC, 0);
        check("fl_valid", bus.OUT_VALID, 0);
        cycle();
        check("fl_next_valid", bus.OUT_VALID, 1);
        check("fl_next_data", bus.OUT_DATA, 8'h44);
        drain();

        // FETCH_EN low: no pops from the FIFO, buffer still drains.
        fifo_write(8'h01); fifo_write(8'h02); fifo_write(8'h03);
        set_inputs(1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        clear_logs();
        set_inputs(1'b0, 1'b1, 1'b0);
        repeat (4) cycle();
        check("fe_no_inc", sum_q(cyc_inc, 0, 3), 0);
        check("fe_drained", sum_q(cyc_pop, 0, 3), 2);
        check("fe_occ", bus.OCC, 0);
        drain();

        // Sustained one word per cycle.
        clear_logs();
        for (int i = 0; i < 16; i++) fifo_write(W'(8'h80 + i));
        set_inputs(1'b1, 1'b1, 1'b0);
        repeat (16) cycle();
        check("tp_inc", sum_q(cyc_inc, 0, 15), 16);
        check("tp_pops", sum_q(cyc_pop, 0, 15), 15);
        drain();

        // Asynchronous reset with two words buffered and two left in the FIFO.
        for (int i = 0; i < 4; i++) fifo_write(W'(8'hC0 + i));
        set_inputs(1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        R_RST = 1'b0;
        #1;
        check("mr_r_inc", bus.R_INC, 0);
        check("mr_valid", bus.OUT_VALID, 0);
        check("mr_occ", bus.OCC, 0);
        check("mr_data", bus.OUT_DATA, 0);
        drop_buffered();
        @(negedge R_CLK);
        bus.OUT_READY = 1'b1;
        repeat (2) cycle();
        R_RST = 1'b1;
        drain();

        // Randomized REMPTY / OUT_READY / FETCH_EN over 1000 words.
        writes = 0;
        start  = n_deliv;
        cyc    = 0;
        while ((n_deliv - start) < 1000 && cyc < 20000) begin
            if (writes < 1000 && !fifo_full() && $urandom_range(0, 3) != 0) begin
                fifo_write(W'($urandom_range(0, 255)));
                writes++;
            end
            hide          = ($urandom_range(0, 3) == 0);
            bus.OUT_READY = 1'($urandom_range(0, 1));
            bus.FETCH_EN  = ($urandom_range(0, 7) != 0);
            bus.FLUSH     = 1'b0;
            cycle();
            cyc++;
        end
        check("rand_delivered", n_deliv - start, 1000);
        check("rand_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
